// File: rtl/multicycle_maindec_if.sv
// Control bundle between the multicycle main decoder and the MIPS datapath.
// The controller uses the master modport and the datapath uses the slave modport.
interface multicycle_maindec_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       branch;
  logic       branch_ne;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic [3:0] state_o;
  logic       illegal;

  modport master (
    input  op, mem_ready,
    output pcwrite, branch, branch_ne, irwrite, regwrite, memwrite, iord,
           memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop, state_o, illegal
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, branch, branch_ne, irwrite, regwrite, memwrite, iord,
           memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop, state_o, illegal
  );
endinterface

// File: rtl/multicycle_maindec.sv
// Moore main controller for the multicycle MIPS datapath. Datapath controls are registered from the next state.
// The only exception is the FETCH-cycle irwrite/pcwrite, which is gated by mem_ready.
module multicycle_maindec #(
  parameter logic [5:0] OP_RTYPE    = 6'b000000,
  parameter logic [5:0] OP_LW       = 6'b100011,
  parameter logic [5:0] OP_SW       = 6'b101011,
  parameter logic [5:0] OP_BEQ      = 6'b000100,
  parameter logic [5:0] OP_BNE      = 6'b000101,
  parameter logic [5:0] OP_ADDI     = 6'b001000,
  parameter logic [5:0] OP_J        = 6'b000010,
  parameter bit         SUPPORT_BNE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_maindec_if.master bus
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11,
    S_BNEEX  = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  typedef struct packed {
    logic       fetch;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  state_t r_state;
  ctrl_t  r_ctrl;
  logic   r_illegal;
  state_t w_next;
  logic   w_fetch_go;

  function automatic state_t next_state(input state_t s, input logic [5:0] op, input logic mr);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = mr ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW)        n = S_MEMADR;
        else if (op == OP_RTYPE)               n = S_EXEC;
        else if (op == OP_BEQ)                 n = S_BEQEX;
        else if (SUPPORT_BNE && op == OP_BNE)  n = S_BNEEX;
        else if (op == OP_ADDI)                n = S_ADDIEX;
        else if (op == OP_J)                   n = S_JEX;
        else                                   n = S_TRAP;
      end
      S_MEMADR: n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  n = mr ? S_MEMWB : S_MEMRD;
      S_MEMWR:  n = mr ? S_FETCH : S_MEMWR;
      S_EXEC:   n = S_ALUWB;
      S_ADDIEX: n = S_ADDIWB;
      S_TRAP:   n = S_TRAP;
      default:  n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.fetch = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:  c.iord = 1'b1;
      S_MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_EXEC:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_ALUWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BEQEX:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      S_BNEEX:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch_ne = 1'b1; end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JEX:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  assign w_next = next_state(r_state, bus.op, bus.mem_ready);

  // Controls are loaded for the state being entered, so they are valid for the whole cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= decode(S_FETCH);
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ctrl    <= decode(w_next);
      r_illegal <= r_illegal | (w_next == S_TRAP);
    end
  end

  // Instruction fetch commits only in the cycle memory reports done.
  assign w_fetch_go    = r_ctrl.fetch & bus.mem_ready & ~reset;

  assign bus.pcwrite   = r_ctrl.pcwrite | w_fetch_go;
  assign bus.irwrite   = w_fetch_go;
  assign bus.branch    = r_ctrl.branch;
  assign bus.branch_ne = r_ctrl.branch_ne;
  assign bus.regwrite  = r_ctrl.regwrite;
  assign bus.memwrite  = r_ctrl.memwrite;
  assign bus.iord      = r_ctrl.iord;
  assign bus.memtoreg  = r_ctrl.memtoreg;
  assign bus.regdst    = r_ctrl.regdst;
  assign bus.alusrca   = r_ctrl.alusrca;
  assign bus.alusrcb   = r_ctrl.alusrcb;
  assign bus.pcsrc     = r_ctrl.pcsrc;
  assign bus.aluop     = r_ctrl.aluop;
  assign bus.state_o   = r_state;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Bench for multicycle_maindec. It drives two instances, one with bne supported and one with bne trapping,
// using the same stimulus, and checks both against an instruction-path model.
module tb_multicycle_maindec;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;

  int n_chk  = 0;
  int n_fail = 0;

  multicycle_maindec_if b0 ();
  multicycle_maindec_if b1 ();

  assign b0.op = op;
  assign b0.mem_ready = mem_ready;
  assign b1.op = op;
  assign b1.mem_ready = mem_ready;

  multicycle_maindec #(.SUPPORT_BNE(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(b0.master));
  multicycle_maindec #(.SUPPORT_BNE(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(b1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each instruction is the ordered list of states it visits after FETCH.
  function automatic int path_at(input logic [5:0] o, input bit bne_ok, input int k);
    int p[4];
    int n;
    p = '{1, 13, 0, 0};
    n = 2;
    case (o)
      6'b000000: begin p = '{1, 6, 7, 0};  n = 3; end
      6'b100011: begin p = '{1, 2, 3, 4};  n = 4; end
      6'b101011: begin p = '{1, 2, 5, 0};  n = 3; end
      6'b000100: begin p = '{1, 8, 0, 0};  n = 2; end
      6'b000101: begin p = bne_ok ? '{1, 12, 0, 0} : '{1, 13, 0, 0}; n = 2; end
      6'b001000: begin p = '{1, 9, 10, 0}; n = 3; end
      6'b000010: begin p = '{1, 11, 0, 0}; n = 2; end
      default:   begin p = '{1, 13, 0, 0}; n = 2; end
    endcase
    return (k < n) ? p[k] : -1;
  endfunction

  // Expected {pcwrite,branch,branch_ne,irwrite,regwrite,memwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,aluop}
  function automatic logic [15:0] exp_ctrl(input int s, input logic mr, input logic rst);
    logic pw, br, bn, ir, rw, mw, io, mt, rd, sa;
    logic [1:0] sb, ps, ao;
    {pw, br, bn, ir, rw, mw, io, mt, rd, sa} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (s)
      0:  begin sb = 2'b01; pw = mr & ~rst; ir = mr & ~rst; end
      1:  sb = 2'b11;
      2, 9: begin sa = 1'b1; sb = 2'b10; end
      3:  io = 1'b1;
      4:  begin mt = 1'b1; rw = 1'b1; end
      5:  begin io = 1'b1; mw = 1'b1; end
      6:  begin sa = 1'b1; ao = 2'b10; end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
      10: rw = 1'b1;
      11: begin ps = 2'b10; pw = 1'b1; end
      12: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; bn = 1'b1; end
      default: ;
    endcase
    return {pw, br, bn, ir, rw, mw, io, mt, rd, sa, sb, ps, ao};
  endfunction

  int         ms[2]   = '{0, 0};
  int         mk[2]   = '{0, 0};
  logic [5:0] mo[2]   = '{6'd0, 6'd0};
  logic       mill[2] = '{1'b0, 1'b0};

  task automatic mstep(input int d, input bit bne_ok);
    if (ms[d] == 13) begin
      ms[d] = 13;
    end else if (ms[d] == 0) begin
      if (mem_ready) begin
        mo[d] = op;
        mk[d] = 0;
        ms[d] = path_at(mo[d], bne_ok, 0);
      end
    end else if ((ms[d] == 3 || ms[d] == 5) && !mem_ready) begin
      ms[d] = ms[d];
    end else begin
      mk[d] = mk[d] + 1;
      ms[d] = path_at(mo[d], bne_ok, mk[d]);
      if (ms[d] < 0) ms[d] = 0;
    end
    if (ms[d] == 13) mill[d] = 1'b1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        ms[d] = 0; mk[d] = 0; mill[d] = 1'b0;
      end
    end else begin
      mstep(0, 1'b1);
      mstep(1, 1'b0);
    end
  end

  wire [15:0] w_act0 = {b0.pcwrite, b0.branch, b0.branch_ne, b0.irwrite, b0.regwrite, b0.memwrite,
                        b0.iord, b0.memtoreg, b0.regdst, b0.alusrca, b0.alusrcb, b0.pcsrc, b0.aluop};
  wire [15:0] w_act1 = {b1.pcwrite, b1.branch, b1.branch_ne, b1.irwrite, b1.regwrite, b1.memwrite,
                        b1.iord, b1.memtoreg, b1.regdst, b1.alusrca, b1.alusrcb, b1.pcsrc, b1.aluop};

  always @(negedge clk) begin
    chk("dut0 state",   32'(b0.state_o), 32'(ms[0]));
    chk("dut0 ctrl",    32'(w_act0),     32'(exp_ctrl(ms[0], mem_ready, reset)));
    chk("dut0 illegal", 32'(b0.illegal), 32'(mill[0]));
    chk("dut1 state",   32'(b1.state_o), 32'(ms[1]));
    chk("dut1 ctrl",    32'(w_act1),     32'(exp_ctrl(ms[1], mem_ready, reset)));
    chk("dut1 illegal", 32'(b1.illegal), 32'(mill[1]));
  end

  // One cycle of stimulus. It checks the literal state of dut0 during that cycle.
  task automatic cyc(input logic mr, input int exp_s);
    mem_ready = mr;
    @(negedge clk);
    chk("seq state", 32'(b0.state_o), 32'(exp_s));
    if (exp_s == 0) chk("fetch irwrite", 32'(b0.irwrite), 32'(mr));
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    op = 6'b000000;
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("reset state",   32'(b0.state_o), 32'd0);
    chk("reset pcwrite", 32'(b0.pcwrite), 32'd0);
    chk("reset irwrite", 32'(b0.irwrite), 32'd0);
    chk("reset alusrcb", 32'(b0.alusrcb), 32'd1);
    reset = 1'b0;

    // R-type
    op = 6'b000000;
    cyc(1, 0); cyc(1, 1);
    chk("exec aluop", 32'(b0.aluop), 32'd2);
    cyc(1, 6);
    chk("aluwb regwrite", 32'(b0.regwrite), 32'd1);
    chk("aluwb regdst",   32'(b0.regdst),   32'd1);
    cyc(1, 7);

    // lw with two MEMRD wait cycles
    op = 6'b100011;
    cyc(1, 0); cyc(1, 1); cyc(1, 2); cyc(0, 3); cyc(0, 3); cyc(1, 3);
    chk("memwb memtoreg", 32'(b0.memtoreg), 32'd1);
    chk("memwb regwrite", 32'(b0.regwrite), 32'd1);
    cyc(1, 4);

    // sw
    op = 6'b101011;
    cyc(1, 0); cyc(1, 1); cyc(1, 2);
    chk("memwr memwrite", 32'(b0.memwrite), 32'd1);
    chk("memwr iord",     32'(b0.iord),     32'd1);
    cyc(1, 5);

    // beq
    op = 6'b000100;
    cyc(1, 0); cyc(1, 1);
    chk("beqex branch", 32'(b0.branch), 32'd1);
    chk("beqex pcsrc",  32'(b0.pcsrc),  32'd1);
    cyc(1, 8);

    // addi
    op = 6'b001000;
    cyc(1, 0); cyc(1, 1); cyc(1, 9); cyc(1, 10);

    // j
    op = 6'b000010;
    cyc(1, 0); cyc(1, 1);
    chk("jex pcwrite", 32'(b0.pcwrite), 32'd1);
    chk("jex pcsrc",   32'(b0.pcsrc),   32'd2);
    cyc(1, 11);

    // Three FETCH wait cycles before an R-type
    op = 6'b000000;
    cyc(0, 0); cyc(0, 0); cyc(0, 0);
    cyc(1, 0); cyc(1, 1); cyc(1, 6); cyc(1, 7);

    // bne: the supporting instance branches and the other instance traps
    op = 6'b000101;
    cyc(1, 0); cyc(1, 1);
    chk("bneex branch_ne", 32'(b0.branch_ne), 32'd1);
    chk("bneex pcsrc",     32'(b0.pcsrc),     32'd1);
    chk("trap state",      32'(b1.state_o),   32'd13);
    chk("trap illegal",    32'(b1.illegal),   32'd1);
    cyc(1, 12);

    // sw, with reset applied during a MEMWR wait cycle
    op = 6'b101011;
    cyc(1, 0); cyc(1, 1); cyc(1, 2); cyc(0, 5);
    chk("memwr wait memwrite", 32'(b0.memwrite), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async reset state",    32'(b0.state_o),  32'd0);
    chk("async reset memwrite", 32'(b0.memwrite), 32'd0);
    chk("async reset illegal",  32'(b1.illegal),  32'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    // The controller resumes from FETCH after reset.
    op = 6'b000000;
    cyc(1, 0); cyc(1, 1); cyc(1, 6); cyc(1, 7);

    // An undefined opcode traps both instances, and the trap persists.
    op = 6'b111111;
    cyc(1, 0); cyc(1, 1);
    chk("illegal op state", 32'(b0.state_o), 32'd13);
    chk("illegal op flag",  32'(b0.illegal), 32'd1);
    cyc(1, 13);
    op = 6'b000000;
    cyc(1, 13); cyc(0, 13);

    #1 reset = 1'b1;
    #1;
    chk("final reset illegal0", 32'(b0.illegal), 32'd0);
    chk("final reset illegal1", 32'(b1.illegal), 32'd0);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
